dmem_lsu_ctrl: RTL and testbench

Memory-side load/store controller for the data memory. Accepts one load or store per request, tagged with the 4-bit {sign, mask[2:0]} code produced at decode. Drives a word-wide synchronous single-port RAM, performs read-modify-write for byte/halfword stores, and returns lane-aligned, sign/zero-extended load data. Sits between the core's memory stage and the data RAM.

---
 rtl/dmem_pkg.sv | 94 +++++++++
 rtl/dmem_load_extend.sv | 22 ++
 rtl/dmem_lsu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory load/store controller:
//   - FSM state encoding (localparams plus the state_e enum built on them)
//   - access-size mask codes and the sign-extend bit index
//   - lane_merge  : write the store lanes into an old RAM word (read-modify-write)
//   - load_extend : pick the addressed lanes of a RAM word and sign/zero-extend them
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_LD_RD   = 3'd1;
    localparam logic [2:0] ENC_LD_CAP  = 3'd2;
    localparam logic [2:0] ENC_ST_WR   = 3'd3;
    localparam logic [2:0] ENC_RMW_RD  = 3'd4;
    localparam logic [2:0] ENC_RMW_WR  = 3'd5;
    localparam logic [2:0] ENC_RESP    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ENC_IDLE,
        S_LD_RD  = ENC_LD_RD,
        S_LD_CAP = ENC_LD_CAP,
        S_ST_WR  = ENC_ST_WR,
        S_RMW_RD = ENC_RMW_RD,
        S_RMW_WR = ENC_RMW_WR,
        S_RESP   = ENC_RESP
    } state_e;

    localparam logic [2:0] MASK_BYTE = 3'b001;
    localparam logic [2:0] MASK_HALF = 3'b011;
    localparam logic [2:0] MASK_WORD = 3'b111;

    localparam int SIGN_BIT = 3;

    // Replace the lanes selected by (addr_lo, mask) in old_word with the
    // right-justified store data. Unknown mask codes leave the word untouched.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  addr_lo,
        input logic [2:0]  mask
    );
        logic [31:0] w;
        w = old_word;
        case (mask)
            MASK_BYTE: begin
                case (addr_lo)
                    2'd0:    w[7:0]   = wdata[7:0];
                    2'd1:    w[15:8]  = wdata[7:0];
                    2'd2:    w[23:16] = wdata[7:0];
                    default: w[31:24] = wdata[7:0];
                endcase
            end
            MASK_HALF: begin
                // addr_lo[0] is deliberately ignored for halfwords.
                if (addr_lo[1]) w[31:16] = wdata[15:0];
                else            w[15:0]  = wdata[15:0];
            end
            MASK_WORD: w = wdata;
            default:   w = old_word;
        endcase
        return w;
    endfunction

    // Move the addressed field to the LSBs; upper bits copy the field MSB
    // when the sign bit is set, else zero. Words pass through unchanged.
    function automatic logic [31:0] load_extend(
        input logic [31:0] rdata,
        input logic [1:0]  addr_lo,
        input logic [3:0]  sign_mask
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic        s;
        logic [31:0] r;
        s = sign_mask[SIGN_BIT];
        case (addr_lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (sign_mask[2:0])
            MASK_BYTE: r = {{24{s & b[7]}}, b};
            MASK_HALF: r = {{16{s & h[15]}}, h};
            MASK_WORD: r = rdata;
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// -----------------------------------------------------------------------------
// dmem_load_extend
// Combinational load-data aligner: selects the byte/halfword/word addressed by
// addr_lo from a RAM word and sign- or zero-extends it to 32 bits.
// Ports:
//   ram_rdata [31:0] in  : raw word read from the data RAM
//   addr_lo   [1:0]  in  : byte offset within the word
//   sign_mask [3:0]  in  : {sign, mask[2:0]} access code
//   ext_data  [31:0] out : lane-aligned, extended load data
// -----------------------------------------------------------------------------
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] ram_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  sign_mask,
    output logic [31:0] ext_data
);

    assign ext_data = load_extend(ram_rdata, addr_lo, sign_mask);

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl
// Memory-side load/store controller in front of a word-wide synchronous
// single-port data RAM. One request at a time; byte/halfword stores are done
// as read-modify-write, loads return lane-aligned extended data.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the RAM and respond with
//               resp_err=1, resp_rdata=0 one cycle after accept
//   undefined : offending low address bits are ignored, resp_err stays 0
//
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_wdata, req_sign_mask   : request payload ({sign, mask[2:0]})
//   resp_valid                 : one-cycle completion pulse
//   resp_rdata, resp_err       : load data (0 for stores), misalign flag
//   ram_addr, ram_re, ram_we,
//   ram_wdata, ram_rdata       : data RAM interface (read data one cycle later)
// -----------------------------------------------------------------------------
module dmem_lsu_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_sign_mask,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        sign_mask_q, sign_mask_d;
    logic              we_q, we_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [31:0]       load_ext;
    logic              req_mask_ok;
    logic              req_misalign;

    assign req_mask_ok = (req_sign_mask[2:0] == MASK_BYTE) ||
                         (req_sign_mask[2:0] == MASK_HALF) ||
                         (req_sign_mask[2:0] == MASK_WORD);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_misalign = ((req_sign_mask[2:0] == MASK_HALF) && req_addr[0]) ||
                          ((req_sign_mask[2:0] == MASK_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    dmem_load_extend u_load_extend (
        .ram_rdata (ram_rdata),
        .addr_lo   (addr_q[1:0]),
        .sign_mask (sign_mask_q),
        .ext_data  (load_ext)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sign_mask_d  = sign_mask_q;
        we_d         = we_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    sign_mask_d = req_sign_mask;
                    we_d        = req_we;
                    if (!req_mask_ok || req_misalign) begin
                        // No RAM access: straight to the response cycle.
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = req_misalign;
                    end else if (!req_we) begin
                        state_d = S_LD_RD;
                    end else if (req_sign_mask[2:0] == MASK_WORD) begin
                        state_d = S_ST_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LD_RD:  state_d = S_LD_CAP;
            S_LD_CAP: begin
                // RAM read data is valid in this cycle.
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
            end
            S_ST_WR, S_RMW_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'd0;
            end
            S_RMW_RD: state_d = S_RMW_WR;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            sign_mask_q  <= 4'd0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sign_mask_q  <= sign_mask_d;
            we_q         <= we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // RAM strobes decode directly from state so a reset drops them at once.
    assign ram_re    = (state_q == S_LD_RD) || (state_q == S_RMW_RD);
    assign ram_we    = (state_q == S_ST_WR) || (state_q == S_RMW_WR);
    assign ram_addr  = addr_q[ADDR_W-1:2];
    assign ram_wdata = (state_q == S_RMW_WR) ? lane_merge(ram_rdata, wdata_q, addr_q[1:0], sign_mask_q[2:0]) :
                       (state_q == S_ST_WR)  ? wdata_q : 32'd0;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // The latched op type only steers the decision made at accept time.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_lsu_ctrl;

    localparam int ADDR_W = 12;
    localparam int NWORDS = 1 << (ADDR_W - 2);
    localparam int NBYTES = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_sign_mask;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-3:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;

    dmem_lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_sign_mask (req_sign_mask),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .ram_addr      (ram_addr),
        .ram_re        (ram_re),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM seen by the DUT.
    logic [31:0] ram_mem [NWORDS];
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: flat byte-addressed little-endian memory.
    logic [7:0] ref_mem [NBYTES];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;       // latency from model, absolute cycle once queued
        int          strobes;   // ram_re + ram_we cycles expected
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_idle = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [ADDR_W-1:0] a,
                                   input logic [31:0] wd, input logic [3:0] sm);
        exp_t        e;
        int          n;
        int          base;
        logic        mis;
        logic [31:0] v;
        e.rdata = 32'd0; e.err = 1'b0; e.cyc = 1; e.strobes = 0;
        case (sm[2:0])
            3'b001:  n = 1;
            3'b011:  n = 2;
            3'b111:  n = 4;
            default: n = 0;
        endcase
        mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (n > 1) && ((int'(a) % n) != 0);
`endif
        if (n == 0 || mis) begin
            e.err = mis;
            return e;
        end
        base = int'(a) - (int'(a) % n);
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
            e.cyc     = (n == 4) ? 2 : 3;
            e.strobes = (n == 4) ? 1 : 2;
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8*i));
            if (n < 4 && sm[3] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            e.rdata   = v;
            e.cyc     = 3;
            e.strobes = 1;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge with
    // req_valid still asserted (ignored by the busy DUT).
    task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                         input logic [3:0] sm, input bit b2b, input bit track);
        exp_t e;
        int   waited;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_sign_mask = sm;
        waited = 0;
        while (!req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 20) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: req_ready low for %0d cycles, required within 20", waited);
                req_valid = 1'b0;
                return;
            end
        end
        if (b2b) check("b2b_accept_cycle", cyc, exp_idle);
        if (track) begin
            e = model(we, a, wd, sm);
            e.cyc = e.cyc + cyc;
            exp_idle = e.cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: counts RAM strobes and checks every response against the queue.
    int          strobe_cnt = 0;
    logic [31:0] last_rdata = 32'd0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            strobe_cnt = 0;
            last_rdata = 32'd0;
        end else begin
            strobe_cnt = strobe_cnt + int'(ram_re) + int'(ram_we);
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_resp: resp_valid with nothing outstanding, rdata 0x%08h", resp_rdata);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_cycle", cyc, e.cyc);
                    check("ram_strobes", strobe_cnt, e.strobes);
                    last_rdata = e.rdata;
                end
                strobe_cnt = 0;
            end else if (req_ready) begin
                check("rdata_hold", resp_rdata, last_rdata);
            end
        end
    end

    initial begin : main
        logic [31:0] v;
        logic [3:0]  sm;
        int          gap;
        bit          b2b;
        int          waited;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = 32'd0; req_sign_mask = 4'd0;
        for (int w = 0; w < NWORDS; w++) begin
            v = $urandom;
            ram_mem[w] = v;
            for (int i = 0; i < 4; i++) ref_mem[4*w + i] = v[8*i +: 8];
        end

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Word store then word load.
        issue(1'b1, 12'h010, 32'hDEADBEEF, 4'b0111, 1'b0, 1'b1);
        check("sw_ram_we", 32'(ram_we), 32'd1);
        check("sw_ram_wdata", ram_wdata, 32'hDEADBEEF);
        check("sw_ram_addr", 32'(ram_addr), 32'h4);
        issue(1'b0, 12'h010, 32'h0, 4'b0111, 1'b1, 1'b1);
        check("lw_ram_re", 32'(ram_re), 32'd1);

        // Byte RMW over 0x11223344, then LB / LBU.
        issue(1'b1, 12'h010, 32'h11223344, 4'b0111, 1'b1, 1'b1);
        issue(1'b1, 12'h012, 32'hFFFFFFAB, 4'b0001, 1'b1, 1'b1);
        check("sb_rmw_re", 32'(ram_re), 32'd1);
        @(negedge clk);
        check("sb_rmw_we", 32'(ram_we), 32'd1);
        check("sb_rmw_wdata", ram_wdata, 32'h11AB3344);
        issue(1'b0, 12'h012, 32'h0, 4'b1001, 1'b1, 1'b1);
        issue(1'b0, 12'h012, 32'h0, 4'b0001, 1'b1, 1'b1);

        // Half RMW over zero, then LH / LHU.
        issue(1'b1, 12'h014, 32'h0, 4'b0111, 1'b1, 1'b1);
        issue(1'b1, 12'h016, 32'h12348001, 4'b0011, 1'b1, 1'b1);
        @(negedge clk);
        check("sh_rmw_wdata", ram_wdata, 32'h80010000);
        issue(1'b0, 12'h016, 32'h0, 4'b1011, 1'b1, 1'b1);
        issue(1'b0, 12'h016, 32'h0, 4'b0011, 1'b1, 1'b1);

        // Invalid mask: immediate response, no strobes.
        issue(1'b0, 12'h010, 32'h0, 4'b1000, 1'b1, 1'b1);
        check("inv_no_re", 32'(ram_re), 32'd0);
        check("inv_no_we", 32'(ram_we), 32'd0);
        issue(1'b1, 12'h010, 32'h55555555, 4'b0000, 1'b1, 1'b1);

        // Misaligned word load at 0x013 (trap or aligned-down read).
        issue(1'b0, 12'h013, 32'h0, 4'b0111, 1'b1, 1'b1);
        issue(1'b0, 12'h015, 32'h0, 4'b1011, 1'b1, 1'b1);
        idle(4);

        // Reset during RMW_RD drops the access.
        issue(1'b1, 12'h020, 32'hCAFEF00D, 4'b0111, 1'b0, 1'b1);
        idle(3);
        issue(1'b1, 12'h021, 32'h00000055, 4'b0001, 1'b0, 1'b0);
        check("rstmid_re_before", 32'(ram_re), 32'd1);
        #1 rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rstmid_re_drop", 32'(ram_re), 32'd0);
        check("rstmid_we_drop", 32'(ram_we), 32'd0);
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_ready_after", 32'(req_ready), 32'd1);
        issue(1'b0, 12'h020, 32'h0, 4'b0111, 1'b0, 1'b1);
        idle(4);

        // Randomized traffic over a small window to force address reuse.
        b2b = 1'b0;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       sm[2:0] = 3'b000;
                1, 2, 3: sm[2:0] = 3'b001;
                4, 5, 6: sm[2:0] = 3'b011;
                default: sm[2:0] = 3'b111;
            endcase
            sm[3] = 1'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom, sm, b2b, 1'b1);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
            b2b = (gap == 0);
        end
        idle(1);

        waited = 0;
        while (sb_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_outstanding", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
